// File: rtl/ifq_pkg.sv
// Shared types and sizing for the instruction fetch queue.
package ifq_pkg;

    localparam int unsigned IFQ_BW    = 32;
    localparam int unsigned IFQ_DEPTH = 4;
    localparam int unsigned IFQ_PTR_W = $clog2(IFQ_DEPTH);
    localparam int unsigned IFQ_CNT_W = $clog2(IFQ_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RESP,
        DISCARD
    } ifq_state_e;

    typedef struct packed {
        logic [IFQ_BW-1:0] pc;
        logic [IFQ_BW-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with synchronous clear.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  ifq_entry_t       wdata,
    input  logic             pop,
    input  logic             clear,
    output ifq_entry_t       head,
    output logic [CNT_W-1:0] count
);

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: one outstanding imem request, entry FIFO, decode valid/ready.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned BW    = IFQ_BW,
    parameter int unsigned DEPTH = IFQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] pc_in,
    output logic          stall,
    input  logic          flush,
    output logic          imem_req,
    output logic [BW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [BW-1:0] imem_rdata,
    output logic          inst_valid,
    output logic [BW-1:0] inst_data,
    output logic [BW-1:0] inst_pc,
    input  logic          inst_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ifq_state_e       state;
    ifq_state_e       state_nxt;
    logic [BW-1:0]    pend_pc;
    logic [CNT_W-1:0] count;
    ifq_entry_t       head;
    ifq_entry_t       wdata;
    logic             issue;
    logic             resp_ok;
    logic             bypass;
    logic             empty;
    logic             push;
    logic             pop;

    // Only one request is ever outstanding, so in IDLE a free slot is simply count < DEPTH.
    always_comb begin
        imem_req  = rst && (state == IDLE) && !flush && (count < CNT_W'(DEPTH));
        imem_addr = pc_in;
        issue     = imem_req && imem_gnt;
        stall     = !issue;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (imem_rvalid)  state_nxt = IDLE;
                else if (flush)   state_nxt = DISCARD;
            end
            DISCARD: begin
                if (imem_rvalid)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                pend_pc <= pc_in;
            end
        end
    end

    assign empty   = (count == '0);
    assign resp_ok = (state == WAIT_RESP) && imem_rvalid && !flush;

`ifdef IFQ_BYPASS_EN
    assign bypass = resp_ok && empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed response that decode takes immediately never occupies a slot.
    assign push  = resp_ok && !(bypass && inst_ready);
    assign pop   = inst_ready && !empty && !flush;
    assign wdata = '{pc: pend_pc, inst: imem_rdata};

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .clear (flush),
        .head  (head),
        .count (count)
    );

    always_comb begin
        inst_valid = !empty || bypass;
        inst_data  = bypass ? imem_rdata : head.inst;
        inst_pc    = bypass ? pend_pc    : head.pc;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: bench acts as PC register and memory, scoreboard tracks the queue.
module tb_ifetch_queue;

    localparam int unsigned BW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [BW-1:0] pc_in;
    logic          stall;
    logic          flush;
    logic          imem_req;
    logic [BW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [BW-1:0] imem_rdata;
    logic          inst_valid;
    logic [BW-1:0] inst_data;
    logic [BW-1:0] inst_pc;
    logic          inst_ready;

    ifetch_queue #(.BW(BW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: expected queue contents plus the fate of the one outstanding fetch.
    logic [63:0]   sb[$];
    bit            m_out;
    bit            m_disc;
    logic [BW-1:0] m_pc;
    bit            m_acc;
    bit            cyc_req;
    bit            byp_taken;
    bit            run;
    int            ready_pct;
    int            flush_pct;
    logic [BW-1:0] pc;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Driver: PC register and memory behaviour, new inputs just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (run) begin
            if (flush)      pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            else if (m_acc) pc = pc + 32'd4;
            pc_in      = pc;
            flush      = ($urandom_range(0, 99) < flush_pct);
            imem_gnt   = ($urandom_range(0, 99) < 60);
            inst_ready = ($urandom_range(0, 99) < ready_pct);
            if (m_out || m_disc) imem_rvalid = ($urandom_range(0, 99) < 50);
            else                 imem_rvalid = ($urandom_range(0, 99) < 5);
            imem_rdata = $urandom;
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on a decode handshake.
    always begin
        @(negedge clk);
        if (run) begin
            bit          exp_valid;
            bit          byp;
            logic [63:0] hd;
            cyc_req = !flush && !m_out && !m_disc && (sb.size() < DEPTH);
            chk("imem_req", 64'(imem_req), 64'(cyc_req));
            chk("stall", 64'(stall), 64'(!(cyc_req && imem_gnt)));
            if (cyc_req) chk("imem_addr", 64'(imem_addr), 64'(pc_in));
            byp = 1'b0;
`ifdef IFQ_BYPASS_EN
            byp = (sb.size() == 0) && m_out && imem_rvalid && !flush;
`endif
            exp_valid = (sb.size() != 0) || byp;
            chk("inst_valid", 64'(inst_valid), 64'(exp_valid));
            if (exp_valid) begin
                hd = byp ? {m_pc, imem_rdata} : sb[0];
                chk("inst_pc", 64'(inst_pc), 64'(hd[63:32]));
                chk("inst_data", 64'(inst_data), 64'(hd[31:0]));
                if (inst_ready && !flush) begin
                    if (byp) byp_taken = 1'b1;
                    else     void'(sb.pop_front());
                end
            end
        end
    end

    // Model update for the coming edge, after the monitor has settled this cycle.
    always begin
        @(negedge clk);
        #1;
        if (run) begin
            bit issued;
            issued = cyc_req && imem_gnt;
            if (flush) sb.delete();
            if (m_out && imem_rvalid) begin
                if (!flush && !byp_taken) sb.push_back({m_pc, imem_rdata});
                m_out = 1'b0;
            end else if (m_out && flush) begin
                m_out  = 1'b0;
                m_disc = 1'b1;
            end else if (m_disc && imem_rvalid) begin
                m_disc = 1'b0;
            end
            if (issued) begin
                m_out = 1'b1;
                m_pc  = pc_in;
            end
            m_acc     = issued;
            byp_taken = 1'b0;
        end
    end

    task automatic quiet_inputs();
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_out     = 1'b0;
        m_disc    = 1'b0;
        m_pc      = '0;
        m_acc     = 1'b0;
        byp_taken = 1'b0;
        pc        = '0;
        pc_in     = '0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_imem_req"}, 64'(imem_req), 64'd0);
        chk({tag, "_stall"}, 64'(stall), 64'd1);
        chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_inst_data"}, 64'(inst_data), 64'd0);
        chk({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        run = 1'b1;
    endtask

    initial begin
        bit found;
        run       = 1'b0;
        rst       = 1'b0;
        ready_pct = 10;
        flush_pct = 2;
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        release_reset();

        // Low ready drives the queue to full; then drain; then flush-heavy traffic.
        repeat (400) @(posedge clk);
        ready_pct = 90;
        repeat (400) @(posedge clk);
        ready_pct = 50;
        flush_pct = 12;
        repeat (400) @(posedge clk);

        // Reset asserted while a response is outstanding.
        flush_pct = 2;
        found     = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            if (m_out && !found) begin
                found = 1'b1;
                run   = 1'b0;
                rst   = 1'b0;
                quiet_inputs();
                #1;
                check_reset_outputs("midrst");
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL midrst_wait: got no outstanding fetch within 200 cycles");
            run = 1'b0;
            rst = 1'b0;
            quiet_inputs();
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("hold");
        release_reset();
        ready_pct = 60;
        repeat (400) @(posedge clk);
        run = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
